// File: rtl/vote_tally_ranker.sv
// vote_tally_ranker: collects ballots into per-candidate saturating counters
// through a valid/ready handshake, then on close scans the counters one per
// cycle and registers the winner, the runner-up and a tie flag.
// Optional feature: define JUDGE_WEIGHT_EN to make judge ballots add
// JUDGE_WEIGHT instead of 1.
module vote_tally_ranker #(
    parameter int N_CAND       = 4,
    parameter int ID_W         = 2,
    parameter int CNT_W        = 6,
    parameter int JUDGE_WEIGHT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vote_valid,
    input  logic [ID_W-1:0]  vote_id,
    input  logic             vote_is_judge,
    output logic             vote_ready,
    input  logic             close,
    input  logic [ID_W-1:0]  cnt_sel,
    output logic [CNT_W-1:0] cnt_out,
    output logic [CNT_W-1:0] invalid_cnt,
    output logic [ID_W-1:0]  first_id,
    output logic [ID_W-1:0]  second_id,
    output logic             tie,
    output logic             sat,
    output logic             result_valid,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_RANK, S_DONE} state_t;

    // Counter storage covers every encodable ID so any ID indexes safely;
    // slots at or above N_CAND are never written and read back as 0.
    localparam int               N_SLOT    = 2 ** ID_W;
    localparam logic [CNT_W:0]   CNT_MAX   = {1'b0, {CNT_W{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_TOP   = {CNT_W{1'b1}};
    localparam logic [ID_W:0]    N_LIM     = (ID_W + 1)'(N_CAND);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_CAND - 1);
    localparam logic [CNT_W:0]   JUDGE_INC = (CNT_W + 1)'(JUDGE_WEIGHT);

    state_t           state;
    logic [CNT_W-1:0] cnt [N_SLOT];
    logic [ID_W-1:0]  idx;
    logic [ID_W-1:0]  best;
    logic [ID_W-1:0]  second;
    logic             second_vld;

    logic             accept;
    logic             id_ok;
    logic [CNT_W:0]   inc;
    logic [CNT_W:0]   sum;
    logic             clamp;
    logic [CNT_W-1:0] cand_next;
    logic [CNT_W-1:0] inv_next;
    logic [CNT_W-1:0] cur;
    logic [ID_W-1:0]  nbest;
    logic [ID_W-1:0]  nsecond;
    logic             nsecond_vld;

`ifndef JUDGE_WEIGHT_EN
    // Judge flag and weight only matter when the weighting option is built in.
    logic unused_judge;
    assign unused_judge = vote_is_judge ^ (^JUDGE_INC);
`endif

    // Ballot datapath: saturating increment of the addressed counter.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        accept = vote_valid && vote_ready;
        id_ok  = {1'b0, vote_id} < N_LIM;
        inc    = (CNT_W + 1)'(1);
`ifdef JUDGE_WEIGHT_EN
        if (vote_is_judge) begin
            inc = JUDGE_INC;
        end
`endif
        sum       = {1'b0, cnt[vote_id]} + inc;
        clamp     = sum > CNT_MAX;
        cand_next = clamp ? CNT_TOP : sum[CNT_W-1:0];
        inv_next  = (invalid_cnt == CNT_TOP) ? invalid_cnt : invalid_cnt + CNT_W'(1);
    end

    // Ranking step: fold candidate idx into the running best/second pair.
    always_comb begin
        cur         = cnt[idx];
        nbest       = best;
        nsecond     = second;
        nsecond_vld = second_vld;
        if (idx == '0) begin
            nbest       = '0;
            nsecond     = '0;
            nsecond_vld = 1'b0;
        end else if (cur > cnt[best]) begin
            nsecond     = best;
            nsecond_vld = 1'b1;
            nbest       = idx;
        end else if (!second_vld || cur > cnt[second]) begin
            nsecond     = idx;
            nsecond_vld = 1'b1;
        end
    end

    // Selected-counter readback, valid in every state.
    assign cnt_out = ({1'b0, cnt_sel} < N_LIM) ? cnt[cnt_sel] : '0;

    // Control FSM with all registered outputs and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            // NOTE: the counter array is small and must read 0 right after reset, so it is reset like any other register.
            for (int k = 0; k < N_SLOT; k++) begin
                cnt[k] <= '0;
            end
            invalid_cnt  <= '0;
            idx          <= '0;
            best         <= '0;
            second       <= '0;
            second_vld   <= 1'b0;
            first_id     <= '0;
            second_id    <= '0;
            tie          <= 1'b0;
            sat          <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            vote_ready   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        for (int k = 0; k < N_SLOT; k++) begin
                            cnt[k] <= '0;
                        end
                        invalid_cnt  <= '0;
                        sat          <= 1'b0;
                        result_valid <= 1'b0;
                        busy         <= 1'b1;
                        vote_ready   <= 1'b1;
                        state        <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        if (id_ok) begin
                            for (int k = 0; k < N_SLOT; k++) begin
                                if (vote_id == ID_W'(k)) begin
                                    cnt[k] <= cand_next;
                                end
                            end
                            if (clamp) begin
                                sat <= 1'b1;
                            end
                        end else begin
                            invalid_cnt <= inv_next;
                        end
                    end
                    if (close) begin
                        idx        <= '0;
                        vote_ready <= 1'b0;
                        state      <= S_RANK;
                    end
                end
                S_RANK: begin
                    best       <= nbest;
                    second     <= nsecond;
                    second_vld <= nsecond_vld;
                    idx        <= idx + ID_W'(1);
                    if (idx == LAST_ID) begin
                        first_id     <= nbest;
                        second_id    <= nsecond;
                        tie          <= (cnt[nbest] == cnt[nsecond]);
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vote_tally_ranker.sv
// Testbench for vote_tally_ranker. Two instances share one stimulus stream:
// the default 4-candidate build and a 3-candidate build in which ID 3 is an
// out-of-range ballot. A behavioural election model predicts every output.
module tb_vote_tally_ranker;

    localparam int ID_W   = 2;
    localparam int CNT_W  = 6;
    localparam int MAXC   = 63;
`ifdef JUDGE_WEIGHT_EN
    localparam int JWEIGHT = 2;
`else
    localparam int JWEIGHT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             vote_valid;
    logic [ID_W-1:0]  vote_id;
    logic             vote_is_judge;
    logic             close;
    logic [ID_W-1:0]  cnt_sel;

    logic             vote_ready_w   [2];
    logic [CNT_W-1:0] cnt_out_w      [2];
    logic [CNT_W-1:0] invalid_w      [2];
    logic [ID_W-1:0]  first_w        [2];
    logic [ID_W-1:0]  second_w       [2];
    logic             tie_w          [2];
    logic             sat_w          [2];
    logic             rv_w           [2];
    logic             busy_w         [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vote_tally_ranker u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vote_valid),
        .vote_id(vote_id), .vote_is_judge(vote_is_judge), .vote_ready(vote_ready_w[0]),
        .close(close), .cnt_sel(cnt_sel), .cnt_out(cnt_out_w[0]),
        .invalid_cnt(invalid_w[0]), .first_id(first_w[0]), .second_id(second_w[0]),
        .tie(tie_w[0]), .sat(sat_w[0]), .result_valid(rv_w[0]), .busy(busy_w[0])
    );

    vote_tally_ranker #(.N_CAND(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vote_valid),
        .vote_id(vote_id), .vote_is_judge(vote_is_judge), .vote_ready(vote_ready_w[1]),
        .close(close), .cnt_sel(cnt_sel), .cnt_out(cnt_out_w[1]),
        .invalid_cnt(invalid_w[1]), .first_id(first_w[1]), .second_id(second_w[1]),
        .tie(tie_w[1]), .sat(sat_w[1]), .result_valid(rv_w[1]), .busy(busy_w[1])
    );

    // ---------------- behavioural election model ----------------
    typedef enum {P_IDLE, P_COLLECT, P_RANK, P_DONE} phase_t;

    phase_t m_phase  [2];
    int     m_left   [2];
    int     m_cnt    [2][4];
    int     m_inv    [2];
    bit     m_sat    [2];
    int     m_first  [2];
    int     m_second [2];
    bit     m_tie    [2];
    bit     m_rv     [2];

    function automatic int n_of(input int j);
        return (j == 0) ? 4 : 3;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            m_phase[j] = P_IDLE;
            for (int k = 0; k < 4; k++) m_cnt[j][k] = 0;
            m_inv[j] = 0; m_sat[j] = 0; m_first[j] = 0; m_second[j] = 0;
            m_tie[j] = 0; m_rv[j] = 0; m_left[j] = 0;
        end
    endtask

    // Winner: highest count, lowest index. Runner-up: same rule over the rest.
    task automatic model_rank(input int j);
        int best;
        int sec;
        best = 0;
        for (int k = 1; k < n_of(j); k++)
            if (m_cnt[j][k] > m_cnt[j][best]) best = k;
        sec = -1;
        for (int k = 0; k < n_of(j); k++)
            if (k != best && (sec < 0 || m_cnt[j][k] > m_cnt[j][sec])) sec = k;
        m_first[j]  = best;
        m_second[j] = sec;
        m_tie[j]    = (m_cnt[j][best] == m_cnt[j][sec]);
    endtask

    // Applies the effect of the inputs present at one rising edge.
    task automatic model_edge();
        int v;
        if (!rst_n) return;
        for (int j = 0; j < 2; j++) begin
            case (m_phase[j])
                P_IDLE, P_DONE: if (start) begin
                    for (int k = 0; k < 4; k++) m_cnt[j][k] = 0;
                    m_inv[j] = 0; m_sat[j] = 0; m_rv[j] = 0;
                    m_phase[j] = P_COLLECT;
                end
                P_COLLECT: begin
                    if (vote_valid) begin
                        if (int'(vote_id) < n_of(j)) begin
                            v = m_cnt[j][vote_id] + (vote_is_judge ? JWEIGHT : 1);
                            if (v > MAXC) begin
                                m_cnt[j][vote_id] = MAXC;
                                m_sat[j] = 1;
                            end else begin
                                m_cnt[j][vote_id] = v;
                            end
                        end else if (m_inv[j] < MAXC) begin
                            m_inv[j]++;
                        end
                    end
                    if (close) begin
                        m_phase[j] = P_RANK;
                        m_left[j]  = n_of(j);
                    end
                end
                P_RANK: begin
                    m_left[j]--;
                    if (m_left[j] == 0) begin
                        model_rank(j);
                        m_rv[j] = 1;
                        m_phase[j] = P_DONE;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input int inst, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d] t=%0t got=%0d want=%0d", name, inst, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            int sel_exp;
            sel_exp = (int'(cnt_sel) < n_of(j)) ? m_cnt[j][cnt_sel] : 0;
            check("vote_ready", j, int'(vote_ready_w[j]),
                  int'(m_phase[j] == P_COLLECT));
            check("busy", j, int'(busy_w[j]),
                  int'(m_phase[j] == P_COLLECT || m_phase[j] == P_RANK));
            check("result_valid", j, int'(rv_w[j]), int'(m_rv[j]));
            check("cnt_out", j, int'(cnt_out_w[j]), sel_exp);
            check("invalid_cnt", j, int'(invalid_w[j]), m_inv[j]);
            check("first_id", j, int'(first_w[j]), m_first[j]);
            check("second_id", j, int'(second_w[j]), m_second[j]);
            check("tie", j, int'(tie_w[j]), int'(m_tie[j]));
            if (m_inv[j] < MAXC) check("sat", j, int'(sat_w[j]), int'(m_sat[j]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cnt_sel = ID_W'($urandom);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic cast(input int id, input bit judge);
        vote_valid    = 1'b1;
        vote_id       = ID_W'(id);
        vote_is_judge = judge;
        step();
        vote_valid    = 1'b0;
        vote_is_judge = 1'b0;
    endtask

    // Pulses close and waits (bounded) for the default instance's result.
    task automatic close_and_wait(output int edges);
        close = 1'b1;
        step();
        close = 1'b0;
        edges = 1;
        while (!rv_w[0] && edges < 20) begin
            step();
            edges++;
        end
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int edges;
        rst_n = 1'b0; start = 1'b0; vote_valid = 1'b0; vote_id = '0;
        vote_is_judge = 1'b0; close = 1'b0; cnt_sel = '0;
        model_reset();
        step(); step();
        rst_n = 1'b1;
        check("rst_first", 0, int'(first_w[0]), 0);
        check("rst_busy", 0, int'(busy_w[0]), 0);
        step();

        // Scenario 1: basic election and latency.
        do_start();
        cast(1, 0); cast(1, 0); cast(2, 0); cast(0, 0); cast(1, 0); cast(3, 0);
        close = 1'b1;
        step();
        close = 1'b0;
        edges = 1;
        while (!rv_w[0] && edges < 20) begin
            step();
            edges++;
        end
        check("t1_latency", 0, edges, 5);
        check("t1_first", 0, int'(first_w[0]), 1);
        check("t1_second", 0, int'(second_w[0]), 0);
        check("t1_tie", 0, int'(tie_w[0]), 0);
        check("t1_inv_n3", 1, int'(invalid_w[1]), 1);
        cnt_sel = 2'd1; #1;
        check("t1_cnt1", 0, int'(cnt_out_w[0]), 3);
        step();

        // Scenario 2: tie broken toward the lowest index.
        do_start();
        cast(0, 0); cast(0, 0); cast(2, 0); cast(2, 0);
        close_and_wait(edges);
        check("t2_first", 0, int'(first_w[0]), 0);
        check("t2_second", 0, int'(second_w[0]), 2);
        check("t2_tie", 0, int'(tie_w[0]), 1);

        // Scenario 3: saturation.
        do_start();
        for (int i = 0; i < 70; i++) cast(3, 0);
        close_and_wait(edges);
        cnt_sel = 2'd3; #1;
        check("t3_cnt3", 0, int'(cnt_out_w[0]), 63);
        check("t3_sat", 0, int'(sat_w[0]), 1);
        check("t3_first", 0, int'(first_w[0]), 3);
        check("t3_inv_n3", 1, int'(invalid_w[1]), 63);
        step();

        // Scenario 4: ballot on the close edge counts, later ones do not.
        do_start();
        vote_valid = 1'b1; vote_id = 2'd2; vote_is_judge = 1'b0; close = 1'b1;
        step();
        close = 1'b0;
        check("t4_ready_low", 0, int'(vote_ready_w[0]), 0);
        step(); step(); step();
        vote_valid = 1'b0;
        step(); step(); step();
        cnt_sel = 2'd2; #1;
        check("t4_cnt2", 0, int'(cnt_out_w[0]), 1);
        step();

        // Scenario 5: reset during RANK, then a fresh election.
        do_start();
        cast(0, 0); cast(1, 0); cast(1, 0);
        close = 1'b1;
        step();
        close = 1'b0;
        step();
        rst_n = 1'b0;
        model_reset();
        cnt_sel = 2'd1; #1;
        check("t5_rv", 0, int'(rv_w[0]), 0);
        check("t5_busy", 0, int'(busy_w[0]), 0);
        check("t5_first", 0, int'(first_w[0]), 0);
        check("t5_cnt1", 0, int'(cnt_out_w[0]), 0);
        step();
        rst_n = 1'b1;
        step();
        do_start();
        cast(2, 0); cast(2, 0); cast(3, 0);
        close_and_wait(edges);
        check("t5_new_first", 0, int'(first_w[0]), 2);
        check("t5_new_second", 0, int'(second_w[0]), 3);
        check("t5_new_rv", 0, int'(rv_w[0]), 1);

        // Scenario 6: judge weighting.
        do_start();
        cast(0, 1); cast(1, 0); cast(1, 0);
        close_and_wait(edges);
`ifdef JUDGE_WEIGHT_EN
        check("t6_first", 0, int'(first_w[0]), 0);
        check("t6_second", 0, int'(second_w[0]), 1);
        check("t6_tie", 0, int'(tie_w[0]), 1);
`else
        check("t6_first", 0, int'(first_w[0]), 1);
        check("t6_second", 0, int'(second_w[0]), 0);
        check("t6_tie", 0, int'(tie_w[0]), 0);
`endif

        // Randomized traffic, including stray starts, closes and resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                model_reset();
                step();
                rst_n = 1'b1;
            end
            start         = ($urandom_range(0, 24) == 0);
            close         = ($urandom_range(0, 9) == 0);
            vote_valid    = ($urandom_range(0, 2) != 0);
            vote_id       = ID_W'($urandom);
            vote_is_judge = 1'($urandom);
            step();
        end
        start = 1'b0; close = 1'b0; vote_valid = 1'b0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
